// File: rtl/bp_pkg.sv
// Shared branch-predictor types and default history lengths.
package bp_pkg;

    localparam int PC_W          = 16;
    localparam int GHIST_LEN_DEF = 8;
    localparam int LHIST_LEN_DEF = 10;

    // Checkpoint record at default history lengths (tournament predictor view).
    typedef struct packed {
        logic [PC_W-1:0]          pc;
        logic                     pred;
        logic [GHIST_LEN_DEF-1:0] ghist;
        logic [LHIST_LEN_DEF-1:0] lhist;
    } bp_checkpoint_t;

    // Flat width of a checkpoint for arbitrary history lengths.
    function automatic int ckpt_width(input int glen, input int llen);
        return PC_W + 1 + glen + llen;
    endfunction

endpackage

// File: rtl/bp_ckpt_fifo.sv
// Generic DEPTH-entry FIFO with synchronous flush and occupancy count.
module bp_ckpt_fifo #(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 8,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [PTR_W:0]    count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[head_q];

    // Push is dropped when full, pop when empty, so count stays within 0..DEPTH.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers/count; flush wins over everything, including a same-cycle push.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + 1'b1;
            if (do_pop)  head_d = head_q + 1'b1;
            if (do_push && !do_pop) count_d = count_q + 1'b1;
            if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    // Pointer and count state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; stale slots are never read as valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[tail_q] <= wdata_i;
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch checkpoint queue driving the predictor update interface.
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter  int GLOBAL_HISTORY_LEN = GHIST_LEN_DEF,
    parameter  int LOCAL_HISTORY_LEN  = LHIST_LEN_DEF,
    parameter  int DEPTH              = 8,
    localparam int PTR_W              = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [15:0]                   alloc_pc,
    input  logic                          alloc_prediction,
    input  logic [GLOBAL_HISTORY_LEN-1:0] alloc_ghist,
    input  logic [LOCAL_HISTORY_LEN-1:0]  alloc_lhist,
    input  logic                          resolve_valid,
    input  logic                          resolve_taken,
    output logic                          upd_write_enabled,
    output logic                          upd_outcome,
    output logic                          upd_branch_miss,
    output logic [15:0]                   upd_pc,
    output logic [GLOBAL_HISTORY_LEN-1:0] upd_ghist,
    output logic [LOCAL_HISTORY_LEN-1:0]  upd_lhist,
    output logic                          resolve_error,
    output logic [PTR_W:0]                count
);

    localparam int GL = GLOBAL_HISTORY_LEN;
    localparam int LL = LOCAL_HISTORY_LEN;
    localparam int DW = ckpt_width(GL, LL);

    logic [DW-1:0] wdata, rdata;
    logic          full, empty, pop, miss;
    logic [15:0]   rd_pc;
    logic          rd_pred;
    logic [GL-1:0] rd_gh;
    logic [LL-1:0] rd_lh;

    logic          we_q, outcome_q, miss_q, err_q;
    logic [15:0]   pc_q;
    logic [GL-1:0] gh_q;
    logic [LL-1:0] lh_q;

    assign wdata = {alloc_pc, alloc_prediction, alloc_ghist, alloc_lhist};
    assign {rd_pc, rd_pred, rd_gh, rd_lh} = rdata;

    assign alloc_ready = !full;
    assign pop         = resolve_valid && !empty;
    // A miss flushes the whole queue: everything younger is wrong-path.
    assign miss        = pop && (rd_pred != resolve_taken);

    bp_ckpt_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (alloc_valid && alloc_ready),
        .wdata_i (wdata),
        .pop_i   (pop),
        .flush_i (miss),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Registered update stage: strobes pulse one cycle, data holds between pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q      <= 1'b0;
            outcome_q <= 1'b0;
            miss_q    <= 1'b0;
            err_q     <= 1'b0;
            pc_q      <= '0;
            gh_q      <= '0;
            lh_q      <= '0;
        end else begin
            we_q   <= pop;
            miss_q <= miss;
            err_q  <= resolve_valid && empty;
            if (pop) begin
                outcome_q <= resolve_taken;
                pc_q      <= rd_pc;
                gh_q      <= rd_gh;
                lh_q      <= rd_lh;
            end
        end
    end

    assign upd_write_enabled = we_q;
    assign upd_outcome       = outcome_q;
    assign upd_branch_miss   = miss_q;
    assign upd_pc            = pc_q;
    assign upd_ghist         = gh_q;
    assign upd_lhist         = lh_q;
    assign resolve_error     = err_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized + directed bench for branch_resolve_queue against a queue model.
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;

    logic        clk, reset;
    logic        alloc_valid, alloc_ready, alloc_prediction;
    logic [15:0] alloc_pc;
    logic [7:0]  alloc_ghist;
    logic [9:0]  alloc_lhist;
    logic        resolve_valid, resolve_taken;
    logic        upd_write_enabled, upd_outcome, upd_branch_miss, resolve_error;
    logic [15:0] upd_pc;
    logic [7:0]  upd_ghist;
    logic [9:0]  upd_lhist;
    logic [3:0]  count;

    branch_resolve_queue #(.GLOBAL_HISTORY_LEN(8), .LOCAL_HISTORY_LEN(10), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_prediction(alloc_prediction), .alloc_ghist(alloc_ghist), .alloc_lhist(alloc_lhist),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .upd_write_enabled(upd_write_enabled), .upd_outcome(upd_outcome),
        .upd_branch_miss(upd_branch_miss), .upd_pc(upd_pc), .upd_ghist(upd_ghist),
        .upd_lhist(upd_lhist), .resolve_error(resolve_error), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        pred;
        logic [7:0]  gh;
        logic [9:0]  lh;
    } rec_t;

    rec_t        mq[$];
    logic        m_we, m_out, m_miss, m_err;
    logic [15:0] m_pc;
    logic [7:0]  m_gh;
    logic [9:0]  m_lh;
    int          m_pre;
    rec_t        m_r;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: in-order list of records; miss empties it, push sees pre-pop size.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_we = 0; m_out = 0; m_miss = 0; m_err = 0;
            m_pc = 0; m_gh = 0; m_lh = 0;
        end else begin
            m_pre = mq.size();
            m_we = 0; m_miss = 0; m_err = 0;
            if (resolve_valid) begin
                if (m_pre == 0) m_err = 1;
                else begin
                    m_r    = mq.pop_front();
                    m_we   = 1;
                    m_out  = resolve_taken;
                    m_miss = (m_r.pred != resolve_taken);
                    m_pc   = m_r.pc;
                    m_gh   = m_r.gh;
                    m_lh   = m_r.lh;
                end
            end
            if (alloc_valid && m_pre != DEPTH && !m_miss)
                mq.push_back('{alloc_pc, alloc_prediction, alloc_ghist, alloc_lhist});
            if (m_miss) mq.delete();
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() != DEPTH));
            chk("upd_we", 32'(upd_write_enabled), 32'(m_we));
            chk("upd_miss", 32'(upd_branch_miss), 32'(m_miss));
            chk("resolve_error", 32'(resolve_error), 32'(m_err));
            chk("upd_outcome", 32'(upd_outcome), 32'(m_out));
            chk("upd_pc", 32'(upd_pc), 32'(m_pc));
            chk("upd_ghist", 32'(upd_ghist), 32'(m_gh));
            chk("upd_lhist", 32'(upd_lhist), 32'(m_lh));
        end
    end

    // One clock: drive at negedge, return at the next negedge.
    task automatic cyc(input logic av, input logic [15:0] pc, input logic pr,
                       input logic [7:0] gh, input logic [9:0] lh,
                       input logic rv, input logic rt);
        alloc_valid = av; alloc_pc = pc; alloc_prediction = pr;
        alloc_ghist = gh; alloc_lhist = lh;
        resolve_valid = rv; resolve_taken = rt;
        @(posedge clk);
        @(negedge clk);
        alloc_valid = 0; resolve_valid = 0;
    endtask

    task automatic push(input logic [15:0] pc, input logic pr, input logic [7:0] gh);
        cyc(1'b1, pc, pr, gh, pc[9:0] ^ 10'h155, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic t);
        cyc(1'b0, 16'h0, 1'b0, 8'h0, 10'h0, 1'b1, t);
    endtask

    task automatic resolve_ok();
        logic t;
        t = (mq.size() > 0) ? mq[0].pred : 1'b0;
        resolve(t);
    endtask

    initial begin
        logic t;
        reset = 1;
        alloc_valid = 0; alloc_pc = 0; alloc_prediction = 0; alloc_ghist = 0; alloc_lhist = 0;
        resolve_valid = 0; resolve_taken = 0;
        repeat (2) @(negedge clk);
        chk("rst count", 32'(count), 0);
        chk("rst alloc_ready", 32'(alloc_ready), 1);
        chk("rst upd_we", 32'(upd_write_enabled), 0);
        chk("rst resolve_error", 32'(resolve_error), 0);
        #1 reset = 0;
        @(negedge clk);

        // In-order correct resolves.
        push(16'h0010, 1, 8'h11); push(16'h0020, 0, 8'h22); push(16'h0030, 1, 8'h33);
        resolve(1);
        chk("t1 pc0", 32'(upd_pc), 32'h0010); chk("t1 we0", 32'(upd_write_enabled), 1);
        resolve(0);
        chk("t1 pc1", 32'(upd_pc), 32'h0020); chk("t1 miss1", 32'(upd_branch_miss), 0);
        resolve(1);
        chk("t1 pc2", 32'(upd_pc), 32'h0030); chk("t1 count", 32'(count), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t1 we idle", 32'(upd_write_enabled), 0);

        // Mispredict flushes younger entries.
        push(16'h0100, 1, 8'hA5); push(16'h0104, 0, 8'h01);
        push(16'h0108, 1, 8'h02); push(16'h010C, 0, 8'h03);
        resolve(0);
        chk("t2 miss", 32'(upd_branch_miss), 1); chk("t2 ghist", 32'(upd_ghist), 32'hA5);
        chk("t2 outcome", 32'(upd_outcome), 0);   chk("t2 count", 32'(count), 0);
        chk("t2 ready", 32'(alloc_ready), 1);

        // Fill, push at full (ignored), wrap.
        for (int i = 0; i < DEPTH; i++) push(16'h0200 + 16'(i), 1'(i), 8'(i));
        chk("t3 count full", 32'(count), 8); chk("t3 ready full", 32'(alloc_ready), 0);
        push(16'hDEAD, 0, 8'hEE);
        chk("t3 count still full", 32'(count), 8);
        resolve_ok();
        chk("t3 count 7", 32'(count), 7); chk("t3 ready 7", 32'(alloc_ready), 1);
        chk("t3 first pc", 32'(upd_pc), 32'h0200);
        for (int i = 0; i < 10; i++) begin
            push(16'h0300 + 16'(i), 1'(i >> 1), 8'(i));
            resolve_ok();
        end

        // Simultaneous push and pop at count 1.
        while (mq.size() > 0) resolve_ok();
        push(16'h0400, 1, 8'h40);
        cyc(1, 16'h0500, 0, 8'h50, 10'h050, 1, 1);
        chk("t4 count", 32'(count), 1); chk("t4 popped pc", 32'(upd_pc), 32'h0400);
        resolve(0);
        chk("t4 new pc", 32'(upd_pc), 32'h0500);

        // Resolve while empty.
        resolve(1);
        chk("t5 err", 32'(resolve_error), 1); chk("t5 we", 32'(upd_write_enabled), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t5 err clear", 32'(resolve_error), 0);

        // Reset during a resolve cycle with an update pulse pending.
        for (int i = 0; i < 6; i++) push(16'h0600 + 16'(i), 1, 8'(i));
        resolve_ok();
        chk("t6 count 5", 32'(count), 5);
        resolve_valid = 1; resolve_taken = 1;
        #2 reset = 1;
        #1;
        chk("t6 count", 32'(count), 0); chk("t6 we", 32'(upd_write_enabled), 0);
        chk("t6 ready", 32'(alloc_ready), 1); chk("t6 pc", 32'(upd_pc), 0);
        resolve_valid = 0;
        @(negedge clk);
        #1 reset = 0;
        @(negedge clk);

        // Randomized traffic, mostly correct predictions.
        for (int i = 0; i < 1500; i++) begin
            t = (mq.size() > 0 && $urandom_range(99) < 85) ? mq[0].pred : 1'($urandom);
            cyc(1'($urandom_range(9) < 6), 16'($urandom), 1'($urandom), 8'($urandom),
                10'($urandom), 1'($urandom_range(9) < 4), t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
